// File: rtl/axi_interconnect_crossbar_wr_sched_pkg.sv
// Shared types and helpers for the crossbar write-channel scheduler:
// index-width function, FSM state encoding and default watchdog limit.
package axi_interconnect_crossbar_wr_sched_pkg;

  localparam int DEF_TO_CYCLES = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  // Bits needed to hold 'value' (at least 1); used as log2(NUM-1) for index widths.
  function automatic int log2(input int value);
    int r;
    r = 1;
    while ((1 << r) <= value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_arbit_polling.sv
// Round-robin (polling) winner selection: first requester strictly after
// last_user, wrapping through index 0. Purely combinational.
module axi_interconnect_crossbar_arbit_polling #(
  parameter int NUM   = 4,
  parameter int WIDTH = 2
) (
  input  logic [NUM-1:0]   user_req,
  input  logic [WIDTH-1:0] last_user,
  output logic             grant_valid,
  output logic [WIDTH-1:0] grant_idx
);

  logic [WIDTH-1:0] w_cand;

  // Scan farthest-first so the nearest requester after last_user is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_cand      = '0;
    for (int k = NUM; k >= 1; k--) begin
      w_cand = WIDTH'((int'(last_user) + k) % NUM);
      if (user_req[w_cand]) begin
        grant_valid = 1'b1;
        grant_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/axi_interconnect_crossbar_wr_sched.sv
// Per-slave write scheduler: round-robin grant held over AW/W/B, released on B.
// Optional watchdog enabled by defining AXI_XBAR_WR_TIMEOUT_EN.
module axi_interconnect_crossbar_wr_sched
  import axi_interconnect_crossbar_wr_sched_pkg::*;
#(
  parameter int NUM       = 4,
  parameter int WIDTH     = log2(NUM - 1),
  parameter int TO_CYCLES = DEF_TO_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NUM-1:0]   m_req,
  input  logic             aw_hs,
  input  logic             w_last_hs,
  input  logic             b_hs,
  output logic             grant_valid,
  output logic [WIDTH-1:0] grant_idx,
  output logic [NUM-1:0]   grant_onehot,
  output logic             aw_sel,
  output logic             w_sel,
  output logic             b_sel,
  output logic             timeout_err
);

  wr_state_e        r_state, w_state_next;
  logic [WIDTH-1:0] r_grant_idx, w_grant_idx_next;
  logic [WIDTH-1:0] r_last_user, w_last_user_next;
  logic             r_wlast_seen, w_wlast_seen_next;
  logic             w_arb_valid;
  logic [WIDTH-1:0] w_arb_idx;
  logic             w_release;
  logic             w_timeout;

  axi_interconnect_crossbar_arbit_polling #(
    .NUM   (NUM),
    .WIDTH (WIDTH)
  ) u_arbit (
    .user_req    (m_req),
    .last_user   (r_last_user),
    .grant_valid (w_arb_valid),
    .grant_idx   (w_arb_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_idx  <= '0;
      r_last_user  <= WIDTH'(NUM - 1);
      r_wlast_seen <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant_idx  <= w_grant_idx_next;
      r_last_user  <= w_last_user_next;
      r_wlast_seen <= w_wlast_seen_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_grant_idx_next  = r_grant_idx;
    w_last_user_next  = r_last_user;
    w_wlast_seen_next = r_wlast_seen;
    w_release         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_arb_valid) begin
          w_state_next     = ADDR;
          w_grant_idx_next = w_arb_idx;
        end
      end
      ADDR: begin
        // W may complete ahead of AW; remember it so AW goes straight to RESP.
        if (aw_hs) begin
          w_state_next = (w_last_hs || r_wlast_seen) ? RESP : DATA;
        end else if (w_last_hs) begin
          w_wlast_seen_next = 1'b1;
        end
      end
      DATA: begin
        if (w_last_hs) w_state_next = RESP;
      end
      RESP: begin
        if (b_hs) w_release = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
    if (w_timeout) w_release = 1'b1;
    if (w_release) begin
      w_state_next      = IDLE;
      w_last_user_next  = r_grant_idx;
      w_grant_idx_next  = '0;
      w_wlast_seen_next = 1'b0;
    end
  end

  assign grant_valid = (r_state != IDLE);
  assign grant_idx   = r_grant_idx;
  assign aw_sel      = (r_state == ADDR);
  assign w_sel       = ((r_state == ADDR) && !r_wlast_seen) || (r_state == DATA);
  assign b_sel       = (r_state == RESP);

  generate
    for (genvar gi = 0; gi < NUM; gi++) begin : g_onehot
      assign grant_onehot[gi] = grant_valid && (r_grant_idx == WIDTH'(gi));
    end
  endgenerate

`ifdef AXI_XBAR_WR_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts stalled cycles of the current owner; any handshake restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if ((r_state == IDLE) || aw_hs || w_last_hs || b_hs) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout   = (r_state != IDLE) && (r_to_cnt == TO_W'(TO_CYCLES));
  assign timeout_err = w_timeout;
`else
  logic w_unused_to_cycles;
  assign w_unused_to_cycles = (TO_CYCLES > 0);
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_interconnect_crossbar_wr_sched.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a transaction-level model of owner/phase flags.
module tb_axi_interconnect_crossbar_wr_sched;

  localparam int NUM   = 4;
  localparam int WIDTH = 2;
  localparam int TO    = 16;

  logic             clk;
  logic             rst_n;
  logic [NUM-1:0]   m_req;
  logic             aw_hs;
  logic             w_last_hs;
  logic             b_hs;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_idx;
  logic [NUM-1:0]   grant_onehot;
  logic             aw_sel;
  logic             w_sel;
  logic             b_sel;
  logic             timeout_err;

  axi_interconnect_crossbar_wr_sched #(
    .NUM       (NUM),
    .WIDTH     (WIDTH),
    .TO_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_req        (m_req),
    .aw_hs        (aw_hs),
    .w_last_hs    (w_last_hs),
    .b_hs         (b_hs),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .grant_onehot (grant_onehot),
    .aw_sel       (aw_sel),
    .w_sel        (w_sel),
    .b_sel        (b_sel),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 = none), previous owner, and which
  // halves of the write (address, last data beat) have been accepted.
  int m_owner;
  int m_last;
  bit m_aw_done;
  bit m_wl_done;
  int m_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NUM-1:0] req, input int last);
    for (int k = 1; k <= NUM; k++) begin
      if (req[(last + k) % NUM]) return (last + k) % NUM;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner   = -1;
    m_last    = NUM - 1;
    m_aw_done = 1'b0;
    m_wl_done = 1'b0;
    m_stall   = 0;
  endtask

  task automatic model_release(input string why);
    $display("txn master %0d released (%s)", m_owner, why);
    m_last  = m_owner;
    m_owner = -1;
  endtask

  task automatic model_clock();
    if (m_owner < 0) begin
      m_owner   = pick(m_req, m_last);
      m_aw_done = 1'b0;
      m_wl_done = 1'b0;
      m_stall   = 0;
    end else begin
`ifdef AXI_XBAR_WR_TIMEOUT_EN
      if (m_stall == TO) begin
        model_release("timeout");
        return;
      end
      if (aw_hs || w_last_hs || b_hs) m_stall = 0;
      else m_stall++;
`endif
      if (m_aw_done && m_wl_done) begin
        if (b_hs) model_release("b");
      end else begin
        if (aw_hs) m_aw_done = 1'b1;
        if (w_last_hs) m_wl_done = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    bit own;
    own = (m_owner >= 0);
    check("grant_valid", grant_valid, own);
    check("grant_idx", grant_idx, own ? m_owner : 0);
    check("grant_onehot", grant_onehot, own ? (32'd1 << m_owner) : 0);
    check("aw_sel", aw_sel, own && !m_aw_done);
    check("w_sel", w_sel, own && !m_wl_done);
    check("b_sel", b_sel, own && m_aw_done && m_wl_done);
`ifdef AXI_XBAR_WR_TIMEOUT_EN
    check("timeout_err", timeout_err, own && (m_stall == TO));
`else
    check("timeout_err", timeout_err, 0);
`endif
  endtask

  // Called at a negedge: drive, clock, update model, check at next negedge.
  task automatic step(input logic [NUM-1:0] req, input logic aw, input logic wl, input logic b);
    m_req     = req;
    aw_hs     = aw;
    w_last_hs = wl;
    b_hs      = b;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic full_txn(input logic [NUM-1:0] req, input int exp_idx, input string tag);
    step(req, 0, 0, 0);
    check({tag, "_idx"}, grant_idx, exp_idx);
    step(req, 1, 0, 0);
    step(req, 0, 1, 0);
    step(req, 0, 0, 1);
    check({tag, "_idle"}, grant_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    m_req = '0; aw_hs = 1'b0; w_last_hs = 1'b0; b_hs = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", grant_valid, 0);
    check("rst_onehot", grant_onehot, 0);
    check_outputs();
    rst_n = 1'b1;

    // Single requester from reset; sels follow the phases.
    step(4'b0000, 0, 0, 0);
    check("noreq_valid", grant_valid, 0);
    step(4'b0100, 0, 0, 0);
    check("t1_idx", grant_idx, 2);
    check("t1_onehot", grant_onehot, 4'b0100);
    check("t1_aw_sel", aw_sel, 1);
    step(4'b0000, 1, 0, 0);
    check("t1_data_wsel", w_sel, 1);
    step(4'b0000, 0, 1, 0);
    check("t1_resp_bsel", b_sel, 1);
    step(4'b1111, 0, 0, 1);
    check("t1_release", grant_valid, 0);

    // All requesting: rotation continues after master 2.
    full_txn(4'b1111, 3, "rr3");
    full_txn(4'b1111, 0, "rr0");
    full_txn(4'b1111, 1, "rr1");
    full_txn(4'b1111, 2, "rr2");
    full_txn(4'b1111, 3, "rr3b");
    full_txn(4'b1001, 0, "wrap0");
    full_txn(4'b1001, 3, "wrap3");

    // Sticky grant: owner drops request, others request.
    step(4'b0001, 0, 0, 0);
    step(4'b1110, 0, 0, 0);
    check("sticky_idx", grant_idx, 0);
    // W last ahead of AW, then AW goes straight to RESP.
    step(4'b0000, 0, 1, 0);
    check("early_wsel", w_sel, 0);
    check("early_awsel", aw_sel, 1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 1, 0, 0);
    check("early_resp", b_sel, 1);
    step(4'b0000, 0, 0, 1);
    // AW and W last together.
    step(4'b0010, 0, 0, 0);
    step(4'b0000, 1, 1, 0);
    check("same_resp", b_sel, 1);
    step(4'b0000, 0, 0, 1);

    // Hold in RESP without B.
    step(4'b0100, 0, 0, 0);
    step(4'b0000, 1, 1, 0);
    for (int i = 0; i < TO + 4; i++) step(4'b0000, 0, 0, 0);
`ifdef AXI_XBAR_WR_TIMEOUT_EN
    check("to_released", grant_valid, 0);
`else
    check("hold_valid", grant_valid, 1);
    step(4'b0000, 0, 0, 1);
`endif

    // Asynchronous reset in DATA with master 1 owning.
    step(4'b0000, 0, 0, 0);
    step(4'b0010, 0, 0, 0);
    step(4'b0000, 1, 0, 0);
    check("pre_rst_idx", grant_idx, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", grant_valid, 0);
    check("arst_idx", grant_idx, 0);
    check("arst_wsel", w_sel, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 0, 0, 0);
    check("post_rst_idx", grant_idx, 1);
    step(4'b0000, 1, 1, 0);
    step(4'b0000, 0, 0, 1);

    // Randomized traffic including spurious handshakes.
    for (int i = 0; i < 800; i++) begin
      logic [NUM-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? '0 : NUM'($urandom_range(0, (1 << NUM) - 1));
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
